mem_port_arbiter: RTL

- Shares one single-ported, word-organised memory between the instruction-fetch stage and the data (load/store) stage of the pipelined core.
- Sequences each access over a fixed memory latency.
- Arbitrates simultaneous requests with data priority and a fetch anti-starvation guard.
- Generates per-stage stall signals and supports cancelling an in-flight fetch on branch redirect.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_prio.sv | 37 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_SHIFT = 2;
  localparam int unsigned LAT_W      = 3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  // Descriptor of the access currently occupying the memory port.
  typedef struct packed {
    logic owner;
    logic we;
    logic mis;
  } acc_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data priority selection with a data-run counter that guards fetch from starvation.
module mem_arb_prio #(
  parameter int unsigned MAX_DATA_RUN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic if_flush,
  input  logic d_req,
  output logic grant_d,
  output logic grant_if
);

  localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);

  logic [RUN_W-1:0] run_cnt;
  logic             if_cand;
  logic             fetch_due;

  assign if_cand   = if_req & ~if_flush;
  assign fetch_due = (run_cnt == RUN_W'(MAX_DATA_RUN));
  assign grant_d   = arb_en & d_req & ~(if_cand & fetch_due);
  assign grant_if  = arb_en & if_cand & ~grant_d;

  // Count data grants made while a fetch is waiting; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (!if_req || grant_if) begin
      run_cnt <= '0;
    end else if (grant_d && !fetch_due) begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch and data access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_DATA_RUN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_d,
  output logic              misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  acc_t               acc_q;
  logic               kill_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;
  logic               grant_d, grant_if, grant_any;
  logic               done_c;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[DATA_W-1:ADDR_W+WORD_SHIFT], d_addr[DATA_W-1:ADDR_W+WORD_SHIFT]};

  mem_arb_prio #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (rst && (state_q == IDLE)),
    .if_req  (if_req),
    .if_flush(if_flush),
    .d_req   (d_req),
    .grant_d (grant_d),
    .grant_if(grant_if)
  );

  assign grant_any = grant_d | grant_if;
  assign done_c    = (state_q == WAIT_MEM) && (lat_q == LAT_W'(1));

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next state: issue on a grant, count down the memory latency, then return to idle.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    if (state_q == IDLE) begin
      if (grant_any) begin
        state_d = WAIT_MEM;
        lat_d   = LAT_W'(MEM_LAT);
      end
    end else begin
      lat_d = lat_q - LAT_W'(1);
      if (lat_q == LAT_W'(1)) begin
        state_d = IDLE;
      end
    end
  end

  // Capture the access descriptor at issue, the flush kill, and completed read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      kill_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_any) begin
        acc_q <= '{owner: (grant_d ? OWN_D : OWN_IF),
                   we:    (grant_d & d_we),
                   mis:   (grant_d ? |d_addr[WORD_SHIFT-1:0] : |if_addr[WORD_SHIFT-1:0])};
        kill_q <= 1'b0;
      end else if ((state_q == WAIT_MEM) && (acc_q.owner == OWN_IF) && if_flush) begin
        kill_q <= 1'b1;
      end
      if (if_valid) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_done && !acc_q.we) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Completion pulses; read data is forwarded in the completion cycle and held afterwards.
  assign if_valid = done_c && (acc_q.owner == OWN_IF) && !kill_q && !if_flush;
  assign d_done   = done_c && (acc_q.owner == OWN_D);
  assign misalign = acc_q.mis & (if_valid | d_done);
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign d_rdata  = (d_done && !acc_q.we) ? mem_rdata : d_rdata_q;

  // Memory strobe and payload are driven only in the issue cycle.
  assign mem_en    = grant_any;
  assign mem_we    = grant_d & d_we;
  assign mem_addr  = grant_d  ? d_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT] :
                     grant_if ? if_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT] : '0;
  assign mem_wdata = grant_d ? d_wdata : '0;

  // Stage stalls, forced low while in reset.
  assign stall_if = rst & if_req & ~if_flush & ~if_valid;
  assign stall_d  = rst & d_req & ~d_done;

endmodule
